// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int CNT_W = 4;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately not reset; rdata is gated by the responder.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, WAIT_STATES wait cycles, then a held response.
// Defining DMEM_ERR_CHECK_EN flags misaligned or out-of-range accesses and suppresses their effect.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request captured, wait counter running down
// RESP  | rsp_valid high, response held until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_load_q;
    logic             rsp_err_q;

    logic             cap_we;
    logic             cap_err;
    logic [AW-1:0]    cap_idx;
    logic [31:0]      cap_wdata;
    logic [3:0]       cap_be;

    logic             accept;
    logic             enter_resp;
    logic             live_err;
    logic [AW-1:0]    live_idx;
    logic             acc_we;
    logic             acc_err;
    logic [AW-1:0]    acc_idx;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic [3:0]       ram_we;
    logic             ram_re;
    logic [31:0]      ram_rdata;

    assign live_idx = bus.req_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    // DEPTH is a power of two, so any set bit above the index field is out of range.
    assign live_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:AW+2] != '0);
`else
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[1:0], bus.req_addr[31:AW+2]};
    assign live_err    = 1'b0;
`endif

    assign accept     = bus.req_valid && req_ready_q;
    assign enter_resp = (state == IDLE) ? (accept && (WAIT_STATES == 0))
                                        : ((state == WAIT) && (cnt == '0));

    // With zero wait states the access happens on the acceptance edge, straight from the bus.
    always_comb begin
        acc_we    = cap_we;
        acc_err   = cap_err;
        acc_idx   = cap_idx;
        acc_wdata = cap_wdata;
        acc_be    = cap_be;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_err   = live_err;
            acc_idx   = live_idx;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end
    end

    assign ram_we = (enter_resp && acc_we && !acc_err) ? acc_be : 4'b0000;
    assign ram_re = enter_resp && !acc_we;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .addr  (acc_idx),
        .we    (ram_we),
        .wdata (acc_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            cap_we      <= 1'b0;
            cap_err     <= 1'b0;
            cap_idx     <= '0;
            cap_wdata   <= '0;
            cap_be      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_we      <= bus.req_we;
                        cap_err     <= live_err;
                        cap_idx     <= live_idx;
                        cap_wdata   <= bus.req_wdata;
                        cap_be      <= bus.req_be;
                        cnt         <= CNT_LOAD;
                        req_ready_q <= 1'b0;
                        state       <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_load_q  <= !acc_we && !acc_err;
                rsp_err_q   <= acc_err;
            end else if ((state == RESP) && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
                rsp_load_q  <= 1'b0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with zero wait states, one with two, checked against an array model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 64;
    localparam int WS0   = 0;
    localparam int WS1   = 2;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Index 0 drives the zero-wait instance, index 1 the two-wait instance.
    logic        req_valid_i [2];
    logic        req_we_i    [2];
    logic [31:0] req_addr_i  [2];
    logic [31:0] req_wdata_i [2];
    logic [3:0]  req_be_i    [2];
    logic        rsp_ready_i [2];
    logic        req_ready_o [2];
    logic        rsp_valid_o [2];
    logic [31:0] rsp_rdata_o [2];
    logic        rsp_err_o   [2];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.req_valid = req_valid_i[0];
    assign bus0.req_we    = req_we_i[0];
    assign bus0.req_addr  = req_addr_i[0];
    assign bus0.req_wdata = req_wdata_i[0];
    assign bus0.req_be    = req_be_i[0];
    assign bus0.rsp_ready = rsp_ready_i[0];
    assign req_ready_o[0] = bus0.req_ready;
    assign rsp_valid_o[0] = bus0.rsp_valid;
    assign rsp_rdata_o[0] = bus0.rsp_rdata;
    assign rsp_err_o[0]   = bus0.rsp_err;

    assign bus1.req_valid = req_valid_i[1];
    assign bus1.req_we    = req_we_i[1];
    assign bus1.req_addr  = req_addr_i[1];
    assign bus1.req_wdata = req_wdata_i[1];
    assign bus1.req_be    = req_be_i[1];
    assign bus1.rsp_ready = rsp_ready_i[1];
    assign req_ready_o[1] = bus1.req_ready;
    assign rsp_valid_o[1] = bus1.rsp_valid;
    assign rsp_rdata_o[1] = bus1.rsp_rdata;
    assign rsp_err_o[1]   = bus1.rsp_err;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    // Reference memory per instance, with per-byte "written" flags since RAM starts unknown.
    logic [31:0] mdata  [2][DEPTH];
    logic [3:0]  mknown [2][DEPTH];

    function automatic int ws_of(input int s);
        return (s == 0) ? WS0 : WS1;
    endfunction

    function automatic void model_access(input int s, input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be,
                                         output logic [31:0] exp_rd, output logic exp_err,
                                         output logic rd_known);
        int unsigned idx;
        idx      = (addr >> 2) % DEPTH;
        exp_err  = ERR_EN && (((addr % 4) != 0) || ((addr >> 2) >= DEPTH));
        exp_rd   = 32'h0;
        rd_known = 1'b1;
        if (exp_err) return;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mdata[s][idx][8*b +: 8] = wdata[8*b +: 8];
                    mknown[s][idx][b]       = 1'b1;
                end
            end
        end else begin
            exp_rd   = mdata[s][idx];
            rd_known = &mknown[s][idx];
        end
    endfunction

    // One full transaction; lat counts edges after the acceptance edge until rsp_valid is seen.
    task automatic txn(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, output logic [31:0] rd, output logic er,
                       output int lat, output logic idle_after);
        int n;
        @(negedge clock);
        req_valid_i[s] = 1'b1;
        req_we_i[s]    = we;
        req_addr_i[s]  = addr;
        req_wdata_i[s] = wdata;
        req_be_i[s]    = be;
        rsp_ready_i[s] = (hold == 0);
        n = 0;
        while (!req_ready_o[s] && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        req_valid_i[s] = 1'b0;
        req_we_i[s]    = 1'($urandom);
        req_addr_i[s]  = $urandom;
        req_wdata_i[s] = $urandom;
        req_be_i[s]    = 4'($urandom);
        lat = 0;
        while (!rsp_valid_o[s] && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clock);
            #1;
        end
        rd = rsp_rdata_o[s];
        er = rsp_err_o[s];
        rsp_ready_i[s] = 1'b1;
        @(posedge clock);
        #1;
        idle_after     = req_ready_o[s] && !rsp_valid_o[s];
        rsp_ready_i[s] = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (req_ready_o[s] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready[%0d]: got %b expected 1", s, req_ready_o[s]); end
            n_checks++;
            if (rsp_valid_o[s] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b expected 0", s, rsp_valid_o[s]); end
            n_checks++;
            if (rsp_rdata_o[s] !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata[%0d]: got %h expected 0", s, rsp_rdata_o[s]); end
            n_checks++;
            if (rsp_err_o[s] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err[%0d]: got %b expected 0", s, rsp_err_o[s]); end
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd;
        logic er, eer, kn, idle;
        int lat;
        model_access(1, 1'b1, 32'h10, 32'hDEADBEEF, BE_WORD, erd, eer, kn);
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (lat !== WS1) begin n_fail++; $display("FAIL store_latency: got %0d expected %0d", lat, WS1); end
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h expected 0", rd); end
        n_checks++;
        if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", er); end
        n_checks++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL store_bubble: got %b expected 1", idle); end
        model_access(1, 1'b0, 32'h10, 32'h0, BE_WORD, erd, eer, kn);
        txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat, idle);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
        n_checks++;
        if (lat !== WS1) begin n_fail++; $display("FAIL load_latency: got %0d expected %0d", lat, WS1); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd, erd;
        logic er, eer, kn, idle;
        int lat;
        model_access(1, 1'b1, 32'h10, 32'h000000AA, BE_BYTE0, erd, eer, kn);
        txn(1, 1'b1, 32'h10, 32'h000000AA, BE_BYTE0, 0, rd, er, lat, idle);
        txn(1, 1'b0, 32'h10, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL be_byte0: got %h expected deadbeaa", rd); end
        txn(1, 1'b1, 32'h10, 32'h55555555, 4'b0000, 0, rd, er, lat, idle);
        n_checks++;
        if (lat !== WS1) begin n_fail++; $display("FAIL be_none_latency: got %0d expected %0d", lat, WS1); end
        txn(1, 1'b0, 32'h10, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL be_none_data: got %h expected deadbeaa", rd); end
        model_access(1, 1'b1, 32'h24, 32'h0, BE_WORD, erd, eer, kn);
        txn(1, 1'b1, 32'h24, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        model_access(1, 1'b1, 32'h24, 32'hABCD9999, BE_HALF1, erd, eer, kn);
        txn(1, 1'b1, 32'h24, 32'hABCD9999, BE_HALF1, 0, rd, er, lat, idle);
        txn(1, 1'b0, 32'h24, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (rd !== 32'hABCD0000) begin n_fail++; $display("FAIL be_half1: got %h expected abcd0000", rd); end
        model_access(1, 1'b1, 32'h20, 32'h12345678, BE_WORD, erd, eer, kn);
        txn(1, 1'b1, 32'h20, 32'h12345678, BE_WORD, 0, rd, er, lat, idle);
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic er, idle;
        int n, lat;
        @(negedge clock);
        req_valid_i[1] = 1'b1;
        req_we_i[1]    = 1'b0;
        req_addr_i[1]  = 32'h10;
        req_be_i[1]    = BE_WORD;
        rsp_ready_i[1] = 1'b0;
        @(posedge clock);
        #1;
        // Keep a store request asserted while busy; it must neither be taken nor queued.
        req_we_i[1]    = 1'b1;
        req_wdata_i[1] = 32'h0;
        n = 0;
        while (!rsp_valid_o[1] && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        n_checks++;
        if (n !== WS1) begin n_fail++; $display("FAIL hold_latency: got %0d expected %0d", n, WS1); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if (rsp_valid_o[1] !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 1", k, rsp_valid_o[1]); end
            n_checks++;
            if (rsp_rdata_o[1] !== 32'hDEADBEAA) begin n_fail++; $display("FAIL hold_rdata[%0d]: got %h expected deadbeaa", k, rsp_rdata_o[1]); end
            n_checks++;
            if (req_ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready[%0d]: got %b expected 0", k, req_ready_o[1]); end
        end
        req_valid_i[1] = 1'b0;
        rsp_ready_i[1] = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (req_ready_o[1] !== 1'b1 || rsp_valid_o[1] !== 1'b0)
            begin n_fail++; $display("FAIL hold_release: got ready=%b valid=%b expected ready=1 valid=0", req_ready_o[1], rsp_valid_o[1]); end
        rsp_ready_i[1] = 1'b0;
        txn(1, 1'b0, 32'h10, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL not_queued: got %h expected deadbeaa", rd); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, erd;
        logic er, eer, kn, idle;
        int lat, cnt, bad;
        model_access(0, 1'b1, 32'h40, 32'hA5A50F0F, BE_WORD, erd, eer, kn);
        txn(0, 1'b1, 32'h40, 32'hA5A50F0F, BE_WORD, 0, rd, er, lat, idle);
        model_access(0, 1'b0, 32'h40, 32'h0, BE_WORD, erd, eer, kn);
        txn(0, 1'b0, 32'h40, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (lat !== WS0) begin n_fail++; $display("FAIL zw_latency: got %0d expected %0d", lat, WS0); end
        n_checks++;
        if (rd !== erd) begin n_fail++; $display("FAIL zw_rdata: got %h expected %h", rd, erd); end
        n_checks++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL zw_bubble: got %b expected 1", idle); end
        @(negedge clock);
        req_valid_i[0] = 1'b1;
        req_we_i[0]    = 1'b0;
        req_addr_i[0]  = 32'h40;
        rsp_ready_i[0] = 1'b1;
        cnt = 0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rsp_valid_o[0]) begin
                cnt++;
                if (rsp_rdata_o[0] !== erd) bad++;
            end
        end
        req_valid_i[0] = 1'b0;
        @(negedge clock);
        rsp_ready_i[0] = 1'b0;
        n_checks++;
        if (cnt !== 20 / (WS0 + 2)) begin n_fail++; $display("FAIL zw_throughput: got %0d responses expected %0d", cnt, 20 / (WS0 + 2)); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL zw_b2b_data: got %0d bad responses expected 0", bad); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic er, idle;
        int n, lat;
        @(negedge clock);
        req_valid_i[1] = 1'b1;
        req_we_i[1]    = 1'b1;
        req_addr_i[1]  = 32'h20;
        req_wdata_i[1] = 32'hFFFFFFFF;
        req_be_i[1]    = BE_WORD;
        rsp_ready_i[1] = 1'b1;
        @(posedge clock);
        #1;
        req_valid_i[1] = 1'b0;
        n_checks++;
        if (req_ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL abort_in_wait: got req_ready %b expected 0", req_ready_o[1]); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o[1] !== 1'b1 || rsp_valid_o[1] !== 1'b0 || rsp_rdata_o[1] !== 32'h0 || rsp_err_o[1] !== 1'b0)
            begin n_fail++; $display("FAIL abort_wait_outputs: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                                     req_ready_o[1], rsp_valid_o[1], rsp_rdata_o[1], rsp_err_o[1]); end
        @(negedge clock);
        reset = 1'b1;
        // Abort a load while its response is being held.
        @(negedge clock);
        req_valid_i[1] = 1'b1;
        req_we_i[1]    = 1'b0;
        req_addr_i[1]  = 32'h20;
        rsp_ready_i[1] = 1'b0;
        @(posedge clock);
        #1;
        req_valid_i[1] = 1'b0;
        n = 0;
        while (!rsp_valid_o[1] && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        n_checks++;
        if (rsp_rdata_o[1] !== 32'h12345678) begin n_fail++; $display("FAIL abort_store_kept: got %h expected 12345678", rsp_rdata_o[1]); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o[1] !== 1'b1 || rsp_valid_o[1] !== 1'b0 || rsp_rdata_o[1] !== 32'h0 || rsp_err_o[1] !== 1'b0)
            begin n_fail++; $display("FAIL abort_resp_outputs: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                                     req_ready_o[1], rsp_valid_o[1], rsp_rdata_o[1], rsp_err_o[1]); end
        @(negedge clock);
        reset = 1'b1;
        txn(1, 1'b0, 32'h20, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (rd !== 32'h12345678) begin n_fail++; $display("FAIL abort_after_load: got %h expected 12345678", rd); end
    endtask

    task automatic test_err();
        logic [31:0] rd, erd, exp_w0, exp_13;
        logic er, eer, kn, idle;
        int lat;
        exp_w0 = ERR_EN ? 32'h11111111 : 32'hCAFEF00D;
        exp_13 = ERR_EN ? 32'h0 : 32'hDEADBEAA;
        model_access(1, 1'b1, 32'h0, 32'h11111111, BE_WORD, erd, eer, kn);
        txn(1, 1'b1, 32'h0, 32'h11111111, BE_WORD, 0, rd, er, lat, idle);
        model_access(1, 1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, BE_WORD, erd, eer, kn);
        txn(1, 1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (er !== ERR_EN) begin n_fail++; $display("FAIL err_oob_store: got %b expected %b", er, ERR_EN); end
        n_checks++;
        if (lat !== WS1) begin n_fail++; $display("FAIL err_oob_latency: got %0d expected %0d", lat, WS1); end
        model_access(1, 1'b0, 32'h0, 32'h0, BE_WORD, erd, eer, kn);
        txn(1, 1'b0, 32'h0, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (rd !== exp_w0) begin n_fail++; $display("FAIL err_word0: got %h expected %h", rd, exp_w0); end
        model_access(1, 1'b0, 32'h13, 32'h0, BE_WORD, erd, eer, kn);
        txn(1, 1'b0, 32'h13, 32'h0, BE_WORD, 0, rd, er, lat, idle);
        n_checks++;
        if (er !== ERR_EN) begin n_fail++; $display("FAIL err_misaligned: got %b expected %b", er, ERR_EN); end
        n_checks++;
        if (rd !== exp_13) begin n_fail++; $display("FAIL err_misaligned_rdata: got %h expected %h", rd, exp_13); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wdata;
        logic er, eer, kn, idle, we;
        logic [3:0] be;
        int lat, s, hold;
        for (int i = 0; i < 80; i++) begin
            s     = int'($urandom_range(0, 1));
            we    = 1'($urandom);
            addr  = 32'($urandom_range(0, 4 * DEPTH + 15));
            wdata = $urandom;
            be    = 4'($urandom);
            hold  = int'($urandom_range(0, 2));
            model_access(s, we, addr, wdata, be, erd, eer, kn);
            txn(s, we, addr, wdata, be, hold, rd, er, lat, idle);
            n_checks++;
            if (lat !== ws_of(s)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, ws_of(s)); end
            n_checks++;
            if (er !== eer) begin n_fail++; $display("FAIL rnd_err[%0d]: addr %h got %b expected %b", i, addr, er, eer); end
            if (kn) begin
                n_checks++;
                if (rd !== erd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: addr %h we %b got %h expected %h", i, addr, we, rd, erd); end
            end
            n_checks++;
            if (idle !== 1'b1) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %b expected 1", i, idle); end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid_i[s] = 1'b0;
            req_we_i[s]    = 1'b0;
            req_addr_i[s]  = 32'h0;
            req_wdata_i[s] = 32'h0;
            req_be_i[s]    = 4'h0;
            rsp_ready_i[s] = 1'b0;
            for (int w = 0; w < DEPTH; w++) begin
                mdata[s][w]  = 32'h0;
                mknown[s][w] = 4'h0;
            end
        end
        test_reset();
        test_basic();
        test_byte_enable();
        test_backpressure();
        test_zero_wait();
        test_reset_abort();
        test_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
